// File: rtl/iob_ptfloat_pack_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ptfloat_pack_arb_pkg
//  Purpose  : Shared widths and helpers for the pack-unit arbiter.
//             EXP_MAX_W / MAN_MAX_W / RES_MAX_W mirror the ptfloat field
//             widths used by iob_ptfloat_pack.
//  Revision : 1.0  initial release
// ============================================================================
package iob_ptfloat_pack_arb_pkg;

    localparam int EXP_MAX_W = 8;   // widest exponent field
    localparam int MAN_MAX_W = 24;  // widest mantissa incl. hidden bit
    localparam int RES_MAX_W = 32;  // unpacked signed mantissa width

    // Next round-robin pointer after a grant; wraps at n_req-1 so that
    // non-power-of-two requester counts never point at a missing slot.
    function automatic int rr_next(input int grant, input int n_req);
        return (grant >= n_req - 1) ? 0 : grant + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : iob_rr_arbiter
//  Purpose  : Combinational round-robin priority search. Grants the first
//             asserted request at or above ptr_i, wrapping modulo N_REQ.
//  Ports    : req_i      in  N_REQ  request vector
//             ptr_i      in  ID_W   highest-priority requester this cycle
//             grant_o    out N_REQ  one-hot grant (zero when no request)
//             grant_id_o out ID_W   encoded grant (zero when no request)
//             any_o      out 1      at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module iob_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             any_o
);

    logic [ID_W:0] w_sum;

    // Walk from ptr_i upward; the extra bit of w_sum lets the wrap be a
    // simple subtract, which also covers non-power-of-two N_REQ.
    always_comb begin
        any_o      = 1'b0;
        grant_id_o = '0;
        w_sum      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!any_o && req_i[w_sum[ID_W-1:0]]) begin
                any_o      = 1'b1;
                grant_id_o = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            grant_o[k] = any_o && (grant_id_o == ID_W'(k));
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_ptfloat_pack_arb.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ptfloat_pack_arb
//  Purpose  : Shares one iob_ptfloat_pack pipeline between N_REQ producers.
//             Round-robin accepts at most one unpacked result per cycle,
//             tracks the owner ID alongside the LAT-deep pack pipeline and
//             returns packed words on one response port. Response
//             back-pressure stalls the pack unit through pack_cke_o.
//  Ports    : clk_i / arst_n_i / cke_i         clock, async reset (low), enable
//             req_valid_i / req_ready_o       per-requester handshake
//             req_exp_i / req_man_i           flattened requester operands
//             pack_cke_o / pack_start_o       pack unit control
//             pack_exp_o / pack_man_o         pack unit operands
//             pack_done_i/data/ovf/unf        pack unit results
//             rsp_valid_o / rsp_ready_i       response handshake
//             rsp_id_o / rsp_data_o           response owner and packed word
//             rsp_ovf_o / rsp_unf_o           response flags
//             err_o                           sticky tracker/pack desync flag
//  Revision : 1.0  initial release
// ============================================================================
module iob_ptfloat_pack_arb
    import iob_ptfloat_pack_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4,
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int LAT    = 2
) (
    input  logic                           clk_i,
    input  logic                           arst_n_i,
    input  logic                           cke_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*(EXP_MAX_W+2)-1:0] req_exp_i,
    input  logic [N_REQ*RES_MAX_W-1:0]     req_man_i,
    output logic                           pack_cke_o,
    output logic                           pack_start_o,
    output logic [EXP_MAX_W+1:0]           pack_exp_o,
    output logic [RES_MAX_W-1:0]           pack_man_o,
    input  logic                           pack_done_i,
    input  logic [DATA_W-1:0]              pack_data_i,
    input  logic                           pack_ovf_i,
    input  logic                           pack_unf_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic [DATA_W-1:0]              rsp_data_o,
    output logic                           rsp_ovf_o,
    output logic                           rsp_unf_o,
    output logic                           err_o
);

    localparam int c_exp_w = EXP_MAX_W + 2;

    // Elaboration-time sanity check of the parameter set.
    if (ID_W != $clog2(N_REQ) || N_REQ < 2 || LAT < 1 || EW_W < 1 || DATA_W < 1)
    begin : g_param_check
        $error("iob_ptfloat_pack_arb: inconsistent parameters");
    end

    logic                     w_adv;
    logic                     w_any;
    logic                     w_accept;
    logic [N_REQ-1:0]         w_grant;
    logic [ID_W-1:0]          w_grant_id;

    logic [ID_W-1:0]          r_rr_ptr;
    logic [LAT-1:0]           r_vld;
    logic [LAT-1:0][ID_W-1:0] r_id;
    logic                     r_err;

    iob_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i      (req_valid_i),
        .ptr_i      (r_rr_ptr),
        .grant_o    (w_grant),
        .grant_id_o (w_grant_id),
        .any_o      (w_any)
    );

    // The pipeline moves only when the output slot is empty or being drained.
    assign w_adv    = cke_i & (~r_vld[LAT-1] | rsp_ready_i);
    assign w_accept = w_adv & w_any;

    // Combinational outputs are masked by reset so nothing leaks while held.
    assign pack_cke_o   = arst_n_i & w_adv;
    assign pack_start_o = arst_n_i & w_accept;
    assign req_ready_o  = (arst_n_i & w_adv) ? w_grant : '0;
    assign pack_exp_o   = arst_n_i ? req_exp_i[w_grant_id*c_exp_w +: c_exp_w]     : '0;
    assign pack_man_o   = arst_n_i ? req_man_i[w_grant_id*RES_MAX_W +: RES_MAX_W] : '0;

    assign rsp_valid_o = r_vld[LAT-1];
    assign rsp_id_o    = r_id[LAT-1];
    assign rsp_data_o  = arst_n_i ? pack_data_i : '0;
    assign rsp_ovf_o   = arst_n_i & pack_ovf_i;
    assign rsp_unf_o   = arst_n_i & pack_unf_i;
    assign err_o       = r_err;

    // Tracker shifts in lock-step with the pack unit registers (both gated
    // by w_adv), so r_vld[LAT-1] must always agree with pack_done_i.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_vld    <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_adv) begin
                r_vld[0] <= w_accept;
                r_id[0]  <= w_grant_id;
                for (int i = 1; i < LAT; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_id[i]  <= r_id[i-1];
                end
            end
            if (w_accept) begin
                r_rr_ptr <= ID_W'(rr_next(int'(w_grant_id), N_REQ));
            end
            if (cke_i && (pack_done_i != r_vld[LAT-1])) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
